alu_issue: RTL and testbench
============================

Name: alu_issue

Overview:
- Operand-issue stage directly upstream of the integer ALU.
- Accepts one 32-bit instruction per cycle and decodes it.
- Reads two 32x32 register banks: bank 0 supplies operand a, bank 1 supplies operand b or the immediate.
- Presents registered a/b/opc/dest/bank/valid to the ALU.
- Owns the register file write port, fed by the ALU writeback bus, with two-level bypass.
- Stalls issue behind an unresolved branch.

Parameters:
- IMM_W, 8, width of the sign-extended immediate field.
- RF_INIT_ZERO, 1, when 1 both register banks are zero-filled by an initial block (simulation/FPGA init; not reset).

Ports:
- core_clock_i  in  1  core clock.
- core_reset_i  in  1  reset, asynchronous, active-high.
- flush_i  in  1  kill all in-flight issue-stage work.
- inst_i  in  32  instruction: [31:25] opc, [24:20] dest, [19] dest bank, [18:14] rs_a (bank 0), [13:9] rs_b (bank 1), [8] use_imm, [7:0] imm.
- inst_valid_i  in  1  inst_i valid.
- inst_ready_o  out  1  instruction accepted this cycle when inst_valid_i is also high.
- a_o  out  32  operand a to ALU.
- b_o  out  32  operand b or immediate to ALU.
- opc_o  out  7  opcode to ALU.
- dest_o  out  5  destination register to ALU.
- bank_o  out  1  destination bank to ALU.
- valid_o  out  1  ALU input valid.
- wb_reg_wen_i  in  1  ALU write enable.
- wb_valid_i  in  1  ALU writeback valid.
- wb_result_i  in  32  ALU result.
- wb_dest_i  in  5  ALU destination register.
- wb_bank_i  in  1  ALU destination bank.
- wb_branch_exec_i  in  1  ALU resolved a branch.
- wb_branch_taken_i  in  1  branch outcome.
- br_resolved_o  out  1  branch resolved, registered pass-through to fetch.
- br_taken_o  out  1  branch taken, registered pass-through to fetch.

Behaviour:
- Reset is async: valid_o, opc_o, dest_o, bank_o, br_resolved_o and br_taken_o are 0; the FSM is ISSUE; both bypass registers are invalid. Register file contents are not reset.
- Accept = inst_valid_i & inst_ready_o. On accept, opc, dest, bank, rs indices, use_imm and imm are registered. Both banks are read synchronously, so data arrives the next cycle.
- valid_o is asserted the cycle after accept, unless flush_i was high in the accept cycle.
- Latency from accept to valid_o is 1 cycle. Throughput is 1 instruction per cycle with no RAW stalls.
- Register write: bank[wb_bank_i][wb_dest_i] <= wb_result_i when wb_reg_wen_i & wb_valid_i & (wb_dest_i != 0).
- Register 0 of each bank reads 0 and is never bypassed.
- Operand a priority:
  1. 0 if rs_a == 0.
  2. Live wb bus, if a write is enabled to bank 0, rs_a (distance 1).
  3. Last-write register, holding the previous cycle's write data/dest/bank (distance 2, covers read-during-write returning old data).
  4. Register file data.
- Operand b follows the same priority against bank 1. When use_imm is set, b_o is the sign-extended imm and no bypass applies.
- a_o and b_o are combinational muxes after the registered read data; they are valid only when valid_o is high.
- FSM:
  - ISSUE: inst_ready_o = 1. Accepting an instruction with opc[6] = 1 (branch) moves to BR_WAIT.
  - BR_WAIT: inst_ready_o = 0. wb_branch_exec_i & wb_valid_i moves to ISSUE; ready is asserted again in the following cycle.
  - flush_i in any state moves to ISSUE, deasserts valid_o next cycle, and drops any accept made in the same cycle.
- br_resolved_o and br_taken_o register wb_branch_exec_i & wb_valid_i and (that) & wb_branch_taken_i.
- A register write in the same cycle as flush_i still commits.
- Reset during BR_WAIT returns to ISSUE immediately.

Decomposition:
- Package alu_issue_pkg holds:
  - Instruction field bit positions.
  - Opcode constants: OPC_ADD 0011000, OPC_SUB 0011001, OPC_XOR 0000000, OPC_BEQ 1000100, etc.
  - The branch-class test on opc[6].
  - FSM state enum {ISSUE, BR_WAIT}.
- One sub-module, alu_regbank: 32x32, one synchronous read port, one write port, instantiated twice.

Test Plan:
- Back-to-back RAW: add r1 = r0 + imm5, then add r2 = r1 + imm3 -> second issue has a_o = 5 via wb bypass; r2 = 8 written.
- Distance-2 hazard: write r4 = 7, one independent instruction, then read r4 -> a_o = 7 via last-write bypass, not the stale 0.
- Immediate sign-extension: imm = 0xFF with use_imm -> b_o = 0xFFFFFFFF; same cycle wb to bank1 rs_b index is ignored.
- Branch stall: issue bne, then hold inst_valid_i -> inst_ready_o is 0 for 2 cycles, br_resolved_o pulses, taken matches; the next instruction is accepted on the third cycle.
- Flush: flush_i asserted with valid_o = 1 and an accept in the same cycle -> valid_o = 0 next cycle, FSM in ISSUE, the concurrent wb write still lands.
- Reset mid-BR_WAIT: assert core_reset_i asynchronously -> valid_o = 0 and inst_ready_o = 1 immediately after release; r0 write attempts read back 0.

Source files
------------

// File: rtl/alu_issue_pkg.sv
// Purpose: shared definitions for the ALU operand-issue stage (fields, opcodes, FSM states).
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package alu_issue_pkg;

   // Instruction field bit positions
   localparam int OPC_MSB       = 31;
   localparam int OPC_LSB       = 25;
   localparam int DEST_MSB      = 24;
   localparam int DEST_LSB      = 20;
   localparam int DBANK_BIT     = 19;
   localparam int RSA_MSB       = 18;
   localparam int RSA_LSB       = 14;
   localparam int RSB_MSB       = 13;
   localparam int RSB_LSB       = 9;
   localparam int USE_IMM_BIT   = 8;
   localparam int IMM_MSB       = 7;
   localparam int IMM_LSB       = 0;
   localparam int OPC_BRANCH_BIT = 6;

   // Opcode constants
   localparam logic [6:0] OPC_XOR = 7'b0000000;
   localparam logic [6:0] OPC_ADD = 7'b0011000;
   localparam logic [6:0] OPC_SUB = 7'b0011001;
   localparam logic [6:0] OPC_BEQ = 7'b1000100;
   localparam logic [6:0] OPC_BNE = 7'b1000101;

   typedef enum logic {
      ISSUE   = 1'b0,
      BR_WAIT = 1'b1
   } issue_state_t;

   typedef struct packed {
      logic [6:0] opc;
      logic [4:0] dest;
      logic       bank;
      logic [4:0] rs_a;
      logic [4:0] rs_b;
      logic       use_imm;
      logic [7:0] imm;
   } inst_t;

   function automatic inst_t decode_inst(input logic [31:0] inst);
      inst_t d;
      d.opc     = inst[OPC_MSB:OPC_LSB];
      d.dest    = inst[DEST_MSB:DEST_LSB];
      d.bank    = inst[DBANK_BIT];
      d.rs_a    = inst[RSA_MSB:RSA_LSB];
      d.rs_b    = inst[RSB_MSB:RSB_LSB];
      d.use_imm = inst[USE_IMM_BIT];
      d.imm     = inst[IMM_MSB:IMM_LSB];
      return d;
   endfunction

   // Any opcode with the top bit set belongs to the branch class
   function automatic logic is_branch(input logic [6:0] opc);
      return opc[OPC_BRANCH_BIT];
   endfunction

endpackage

// File: rtl/alu_issue_if.sv
// Purpose: bundles instruction input, ALU operand output, writeback and branch signals of alu_issue.
// Latency: n/a (wiring only).
// Backpressure: inst_valid_i/inst_ready_o handshake; ALU and writeback side are not backpressured.
// Modports: slave = issue stage, master = surrounding pipeline / testbench.
interface alu_issue_if;
   logic        flush_i;
   logic [31:0] inst_i;
   logic        inst_valid_i;
   logic        inst_ready_o;
   logic [31:0] a_o;
   logic [31:0] b_o;
   logic [6:0]  opc_o;
   logic [4:0]  dest_o;
   logic        bank_o;
   logic        valid_o;
   logic        wb_reg_wen_i;
   logic        wb_valid_i;
   logic [31:0] wb_result_i;
   logic [4:0]  wb_dest_i;
   logic        wb_bank_i;
   logic        wb_branch_exec_i;
   logic        wb_branch_taken_i;
   logic        br_resolved_o;
   logic        br_taken_o;

   modport slave (
      input  flush_i, inst_i, inst_valid_i,
      input  wb_reg_wen_i, wb_valid_i, wb_result_i, wb_dest_i, wb_bank_i,
      input  wb_branch_exec_i, wb_branch_taken_i,
      output inst_ready_o, a_o, b_o, opc_o, dest_o, bank_o, valid_o,
      output br_resolved_o, br_taken_o
   );

   modport master (
      output flush_i, inst_i, inst_valid_i,
      output wb_reg_wen_i, wb_valid_i, wb_result_i, wb_dest_i, wb_bank_i,
      output wb_branch_exec_i, wb_branch_taken_i,
      input  inst_ready_o, a_o, b_o, opc_o, dest_o, bank_o, valid_o,
      input  br_resolved_o, br_taken_o
   );
endinterface

// File: rtl/alu_regbank.sv
// Purpose: 32x32 register bank, one synchronous read port and one write port.
// Latency: read data valid 1 cycle after ren; read-during-write to the same entry returns old data.
// Backpressure: none.
// Ports: clk; we/waddr/wdata write port; ren/raddr read request; rdata registered read data.
module alu_regbank #(
   parameter bit RF_INIT_ZERO = 1'b1
) (
   input  logic        clk,
   input  logic        we,
   input  logic [4:0]  waddr,
   input  logic [31:0] wdata,
   input  logic        ren,
   input  logic [4:0]  raddr,
   output logic [31:0] rdata
);

   logic [31:0] mem [32];

   // Contents are deliberately not reset; optional zero-fill for simulation/FPGA bitstreams.
   generate
      if (RF_INIT_ZERO) begin : g_init
         initial begin
            for (int i = 0; i < 32; i++) mem[i] <= '0;
         end
      end
   endgenerate

   always @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (ren) rdata <= mem[raddr];
   end

endmodule

// File: rtl/alu_issue.sv
// Purpose: operand-issue stage ahead of the integer ALU: decode, dual-bank read, two-level bypass, branch stall.
// Latency: 1 cycle from accept to valid_o; 1 instruction/cycle, no RAW stalls.
// Backpressure: inst_ready_o low while waiting on an unresolved branch; ALU side is never stalled.
// Ports: core_clock_i, core_reset_i (async, active-high), bus (alu_issue_if.slave).
module alu_issue
   import alu_issue_pkg::*;
#(
   parameter int IMM_W        = 8,
   parameter bit RF_INIT_ZERO = 1'b1
) (
   input  logic     core_clock_i,
   input  logic     core_reset_i,
   alu_issue_if.slave bus
);

   inst_t        dec;
   issue_state_t state_q, state_d;
   logic         inst_ready;
   logic         accept;
   logic         wb_wen;
   logic         br_evt;

   // Registered issue fields
   logic             valid_q;
   logic [6:0]       opc_q;
   logic [4:0]       dest_q;
   logic             bank_q;
   logic [4:0]       rs_a_q;
   logic [4:0]       rs_b_q;
   logic             use_imm_q;
   logic [IMM_W-1:0] imm_q;

   // Last-write (distance-2) bypass, one per bank
   logic        lw0_vld, lw1_vld;
   logic [4:0]  lw0_dest, lw1_dest;
   logic [31:0] lw0_data, lw1_data;

   logic [31:0] rd_a, rd_b;
   logic [31:0] a_mux, b_mux;
   logic        br_res_q, br_tkn_q;

   assign dec    = decode_inst(bus.inst_i);
   assign accept = bus.inst_valid_i & inst_ready;
   assign wb_wen = bus.wb_reg_wen_i & bus.wb_valid_i & (bus.wb_dest_i != 5'd0);
   assign br_evt = bus.wb_branch_exec_i & bus.wb_valid_i;

   // FSM: state register
   always_ff @(posedge core_clock_i or posedge core_reset_i) begin
      if (core_reset_i) state_q <= ISSUE;
      else              state_q <= state_d;
   end

   // FSM: next state and ready
   always_comb begin
      state_d    = state_q;
      inst_ready = 1'b0;
      case (state_q)
         ISSUE: begin
            inst_ready = 1'b1;
            if (bus.inst_valid_i && is_branch(dec.opc)) state_d = BR_WAIT;
         end
         BR_WAIT: begin
            if (br_evt) state_d = ISSUE;
         end
         default: state_d = ISSUE;
      endcase
      // Flush also cancels a branch accepted in the same cycle
      if (bus.flush_i) state_d = ISSUE;
   end

   // Issue register: fields follow every accept, valid is dropped by a flush
   always_ff @(posedge core_clock_i or posedge core_reset_i) begin
      if (core_reset_i) begin
         valid_q   <= 1'b0;
         opc_q     <= '0;
         dest_q    <= '0;
         bank_q    <= 1'b0;
         rs_a_q    <= '0;
         rs_b_q    <= '0;
         use_imm_q <= 1'b0;
         imm_q     <= '0;
      end else begin
         valid_q <= accept & ~bus.flush_i;
         if (accept) begin
            opc_q     <= dec.opc;
            dest_q    <= dec.dest;
            bank_q    <= dec.bank;
            rs_a_q    <= dec.rs_a;
            rs_b_q    <= dec.rs_b;
            use_imm_q <= dec.use_imm;
            imm_q     <= dec.imm[IMM_W-1:0];
         end
      end
   end

   // Hold the previous cycle's write so a read issued alongside it sees the new value
   always_ff @(posedge core_clock_i or posedge core_reset_i) begin
      if (core_reset_i) begin
         lw0_vld  <= 1'b0;
         lw1_vld  <= 1'b0;
         lw0_dest <= '0;
         lw1_dest <= '0;
         lw0_data <= '0;
         lw1_data <= '0;
      end else begin
         lw0_vld <= wb_wen & ~bus.wb_bank_i;
         lw1_vld <= wb_wen &  bus.wb_bank_i;
         if (wb_wen && !bus.wb_bank_i) begin
            lw0_dest <= bus.wb_dest_i;
            lw0_data <= bus.wb_result_i;
         end
         if (wb_wen && bus.wb_bank_i) begin
            lw1_dest <= bus.wb_dest_i;
            lw1_data <= bus.wb_result_i;
         end
      end
   end

   // Branch outcome pass-through to fetch
   always_ff @(posedge core_clock_i or posedge core_reset_i) begin
      if (core_reset_i) begin
         br_res_q <= 1'b0;
         br_tkn_q <= 1'b0;
      end else begin
         br_res_q <= br_evt;
         br_tkn_q <= br_evt & bus.wb_branch_taken_i;
      end
   end

   alu_regbank #(.RF_INIT_ZERO(RF_INIT_ZERO)) u_bank0 (
      .clk   (core_clock_i),
      .we    (wb_wen & ~bus.wb_bank_i),
      .waddr (bus.wb_dest_i),
      .wdata (bus.wb_result_i),
      .ren   (accept),
      .raddr (dec.rs_a),
      .rdata (rd_a)
   );

   alu_regbank #(.RF_INIT_ZERO(RF_INIT_ZERO)) u_bank1 (
      .clk   (core_clock_i),
      .we    (wb_wen & bus.wb_bank_i),
      .waddr (bus.wb_dest_i),
      .wdata (bus.wb_result_i),
      .ren   (accept),
      .raddr (dec.rs_b),
      .rdata (rd_b)
   );

   // Operand muxes: r0, live writeback, last write, register file
   always_comb begin
      a_mux = rd_a;
      if (rs_a_q == 5'd0)
         a_mux = '0;
      else if (wb_wen && !bus.wb_bank_i && bus.wb_dest_i == rs_a_q)
         a_mux = bus.wb_result_i;
      else if (lw0_vld && lw0_dest == rs_a_q)
         a_mux = lw0_data;

      b_mux = rd_b;
      if (use_imm_q)
         b_mux = {{(32-IMM_W){imm_q[IMM_W-1]}}, imm_q};
      else if (rs_b_q == 5'd0)
         b_mux = '0;
      else if (wb_wen && bus.wb_bank_i && bus.wb_dest_i == rs_b_q)
         b_mux = bus.wb_result_i;
      else if (lw1_vld && lw1_dest == rs_b_q)
         b_mux = lw1_data;
   end

   assign bus.inst_ready_o  = inst_ready;
   assign bus.a_o           = a_mux;
   assign bus.b_o           = b_mux;
   assign bus.opc_o         = opc_q;
   assign bus.dest_o        = dest_q;
   assign bus.bank_o        = bank_q;
   assign bus.valid_o       = valid_q;
   assign bus.br_resolved_o = br_res_q;
   assign bus.br_taken_o    = br_tkn_q;

endmodule

// File: tb/tb_alu_issue.sv
// Purpose: directed self-checking bench for alu_issue; the bench plays the ALU writeback bus by hand.
// Latency: n/a.
// Backpressure: n/a.
module tb_alu_issue;
   import alu_issue_pkg::*;

   logic clk;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   alu_issue_if bus();

   alu_issue #(.IMM_W(8), .RF_INIT_ZERO(1'b1)) dut (
      .core_clock_i (clk),
      .core_reset_i (rst),
      .bus          (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   function automatic logic [31:0] mk(input logic [6:0] opc, input logic [4:0] dest, input logic bank,
                                      input logic [4:0] ra, input logic [4:0] rb, input logic ui,
                                      input logic [7:0] imm);
      return {opc, dest, bank, ra, rb, ui, imm};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wb(input logic wen, input logic [31:0] res, input logic [4:0] dest, input logic bank);
      bus.wb_reg_wen_i      = wen;
      bus.wb_valid_i        = 1'b1;
      bus.wb_result_i       = res;
      bus.wb_dest_i         = dest;
      bus.wb_bank_i         = bank;
      bus.wb_branch_exec_i  = 1'b0;
      bus.wb_branch_taken_i = 1'b0;
   endtask

   task automatic wb_idle();
      bus.wb_reg_wen_i      = 1'b0;
      bus.wb_valid_i        = 1'b0;
      bus.wb_result_i       = '0;
      bus.wb_dest_i         = '0;
      bus.wb_bank_i         = 1'b0;
      bus.wb_branch_exec_i  = 1'b0;
      bus.wb_branch_taken_i = 1'b0;
   endtask

   task automatic issue(input logic vld, input logic [31:0] inst);
      bus.inst_valid_i = vld;
      bus.inst_i       = inst;
   endtask

   initial begin
      rst         = 1'b1;
      bus.flush_i = 1'b0;
      issue(1'b0, '0);
      wb_idle();

      // Reset state
      #2;
      chk("rst_valid", bus.valid_o, 0);
      chk("rst_opc", bus.opc_o, 0);
      chk("rst_dest", bus.dest_o, 0);
      chk("rst_bank", bus.bank_o, 0);
      chk("rst_br_resolved", bus.br_resolved_o, 0);
      chk("rst_br_taken", bus.br_taken_o, 0);
      chk("rst_ready", bus.inst_ready_o, 1);
      #10 rst = 1'b0;

      // C1: add r1 = r0 + 5
      step();
      issue(1'b1, mk(OPC_ADD, 5'd1, 1'b0, 5'd0, 5'd0, 1'b1, 8'd5));
      #2;
      chk("c1_ready", bus.inst_ready_o, 1);

      // C2: r1 op on ALU; issue add r2 = r1 + 3
      step();
      issue(1'b1, mk(OPC_ADD, 5'd2, 1'b0, 5'd1, 5'd0, 1'b1, 8'd3));
      #2;
      chk("c2_valid", bus.valid_o, 1);
      chk("c2_opc", bus.opc_o, 32'(OPC_ADD));
      chk("c2_dest", bus.dest_o, 1);
      chk("c2_a_r0", bus.a_o, 0);
      chk("c2_b_imm5", bus.b_o, 5);

      // C3: wb r1 = 5 live; second add must see it
      step();
      issue(1'b0, '0);
      wb(1'b1, 32'd5, 5'd1, 1'b0);
      #2;
      chk("c3_valid", bus.valid_o, 1);
      chk("c3_a_wb_bypass", bus.a_o, 5);
      chk("c3_b_imm3", bus.b_o, 3);

      // C4: nothing issued; wb r2 = 8
      step();
      wb(1'b1, 32'd8, 5'd2, 1'b0);
      #2;
      chk("c4_valid_idle", bus.valid_o, 0);

      // C5: xor reading r2 from the register file
      step();
      wb_idle();
      issue(1'b1, mk(OPC_XOR, 5'd5, 1'b1, 5'd2, 5'd0, 1'b0, 8'd0));

      // C6: wb r4 = 7 while sub reading r4 is accepted
      step();
      issue(1'b1, mk(OPC_SUB, 5'd6, 1'b0, 5'd4, 5'd4, 1'b0, 8'd0));
      wb(1'b1, 32'd7, 5'd4, 1'b0);
      #2;
      chk("c6_a_rf_r2", bus.a_o, 8);
      chk("c6_b_r0", bus.b_o, 0);
      chk("c6_bank", bus.bank_o, 1);

      // C7: sub sees r4 through last-write; bank1 r4 untouched
      step();
      wb_idle();
      issue(1'b1, mk(OPC_ADD, 5'd3, 1'b1, 5'd0, 5'd9, 1'b1, 8'hFF));
      #2;
      chk("c7_opc", bus.opc_o, 32'(OPC_SUB));
      chk("c7_a_lastwrite", bus.a_o, 7);
      chk("c7_b_bank1_r4", bus.b_o, 0);

      // C8: imm 0xFF sign-extends; concurrent bank1 r9 write is ignored for b
      step();
      wb(1'b1, 32'h0000_1234, 5'd9, 1'b1);
      issue(1'b1, mk(OPC_XOR, 5'd7, 1'b0, 5'd0, 5'd9, 1'b0, 8'd0));
      #2;
      chk("c8_b_sext", bus.b_o, 32'hFFFF_FFFF);
      chk("c8_a_r0", bus.a_o, 0);

      // C9: xor reads bank1 r9 via last-write; issue bne
      step();
      wb_idle();
      issue(1'b1, mk(OPC_BNE, 5'd0, 1'b0, 5'd1, 5'd0, 1'b0, 8'd0));
      #2;
      chk("c9_b_lastwrite_bank1", bus.b_o, 32'h0000_1234);
      chk("c9_ready", bus.inst_ready_o, 1);

      // C10: BR_WAIT, hold next instruction
      step();
      issue(1'b1, mk(OPC_ADD, 5'd8, 1'b0, 5'd0, 5'd0, 1'b1, 8'h11));
      #2;
      chk("c10_ready_stall", bus.inst_ready_o, 0);
      chk("c10_valid_bne", bus.valid_o, 1);
      chk("c10_opc_bne", bus.opc_o, 32'(OPC_BNE));
      chk("c10_a_rf_r1", bus.a_o, 5);
      chk("c10_br_resolved", bus.br_resolved_o, 0);

      // C11: branch resolves taken on wb
      step();
      bus.wb_valid_i        = 1'b1;
      bus.wb_branch_exec_i  = 1'b1;
      bus.wb_branch_taken_i = 1'b1;
      #2;
      chk("c11_ready_stall", bus.inst_ready_o, 0);
      chk("c11_valid_none", bus.valid_o, 0);

      // C12: ready again, held instruction accepted
      step();
      wb_idle();
      #2;
      chk("c12_ready", bus.inst_ready_o, 1);
      chk("c12_br_resolved", bus.br_resolved_o, 1);
      chk("c12_br_taken", bus.br_taken_o, 1);

      // C13: held add on ALU; flush with a beq accept and a concurrent r10 write
      step();
      #2;
      chk("c13_valid", bus.valid_o, 1);
      chk("c13_dest", bus.dest_o, 8);
      chk("c13_b_imm", bus.b_o, 32'h11);
      chk("c13_br_resolved_pulse", bus.br_resolved_o, 0);
      bus.flush_i = 1'b1;
      issue(1'b1, mk(OPC_BEQ, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 8'd0));
      wb(1'b1, 32'h0000_CAFE, 5'd10, 1'b0);

      // C14: flushed; still in ISSUE; read r10
      step();
      bus.flush_i = 1'b0;
      wb_idle();
      issue(1'b1, mk(OPC_ADD, 5'd11, 1'b0, 5'd10, 5'd0, 1'b1, 8'd0));
      #2;
      chk("c14_valid_flushed", bus.valid_o, 0);
      chk("c14_ready_issue", bus.inst_ready_o, 1);

      // C15: r10 write during flush committed; issue beq and try writing r0
      step();
      issue(1'b1, mk(OPC_BEQ, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 8'd0));
      wb(1'b1, 32'h0000_DEAD, 5'd0, 1'b0);
      #2;
      chk("c15_valid", bus.valid_o, 1);
      chk("c15_a_flush_write", bus.a_o, 32'h0000_CAFE);

      // C16: BR_WAIT, then async reset mid-cycle
      step();
      issue(1'b0, '0);
      wb(1'b1, 32'h0000_BEEF, 5'd0, 1'b1);
      #2;
      chk("c16_ready_stall", bus.inst_ready_o, 0);
      chk("c16_valid", bus.valid_o, 1);
      rst = 1'b1;
      #1;
      chk("c16_async_valid", bus.valid_o, 0);
      chk("c16_async_ready", bus.inst_ready_o, 1);
      chk("c16_async_opc", bus.opc_o, 0);
      #2;
      rst = 1'b0;
      wb_idle();
      #1;
      chk("c16_rel_ready", bus.inst_ready_o, 1);
      chk("c16_rel_valid", bus.valid_o, 0);
      issue(1'b1, mk(OPC_ADD, 5'd12, 1'b0, 5'd0, 5'd0, 1'b0, 8'd0));

      // C17: r0 reads 0 and is never bypassed, even with a live wb to r0
      step();
      issue(1'b0, '0);
      wb(1'b1, 32'hFFFF_FFFF, 5'd0, 1'b0);
      #2;
      chk("c17_valid", bus.valid_o, 1);
      chk("c17_a_r0", bus.a_o, 0);
      chk("c17_b_r0", bus.b_o, 0);

      step();
      wb_idle();
      step();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
